tx_sample_unpacker: RTL and testbench
=====================================

Name: tx_sample_unpacker

Overview:
- Upstream feeder for the transmit DUC chain.
- Pops 16-bit words from a show-ahead TX FIFO and assembles one I/Q sample set per channel (1 or 2 channels).
- Presents each set on i0/q0/i1/q1 in step with the DUC input strobe (strobe1), so each DUC sees one new sample per strobe.
- Detects FIFO underrun, substitutes zeros and reports it through a sticky flag and a saturating counter.

Parameters:
WIDTH, 16, sample and FIFO word width
UCNT_W, 16, underrun counter width

Ports:
clock  in  1  single system clock; all logic on posedge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  block enable; low = synchronous flush to IDLE
dual  in  1  0 = one channel (I0,Q0), 1 = two channels (I0,Q0,I1,Q1); sampled only while enable low
strobe  in  1  DUC input strobe (from the DUC strobe output), one-cycle pulse
fifo_data  in  WIDTH  head-of-FIFO word, valid when fifo_empty low
fifo_empty  in  1  FIFO empty flag
fifo_rdreq  out  1  pop request; combinational
i0_out  out  WIDTH  channel 0 I sample
q0_out  out  WIDTH  channel 0 Q sample
i1_out  out  WIDTH  channel 1 I sample; 0 when dual=0
q1_out  out  WIDTH  channel 1 Q sample; 0 when dual=0
clear_status  in  1  synchronous clear of underrun and ucount
underrun  out  1  sticky underrun flag
ucount  out  UCNT_W  saturating count of underrun strobes

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - all outputs 0 (fifo_rdreq 0)
  - state IDLE; wcnt 0; staging regs 0
  - dual_r 0; underrun 0; ucount 0
- States: IDLE, FILL, FULL.
  - IDLE: entered at reset or whenever enable=0.
    - Each cycle: dual_r <= dual; staging, wcnt and outputs are cleared to 0.
    - underrun and ucount are held.
    - enable=1 -> FILL.
  - FILL: fifo_rdreq = ~fifo_empty.
    - On each pop: staging[wcnt] <= fifo_data, wcnt++.
    - Word order: I0,Q0 when dual_r=0; I0,Q0,I1,Q1 when dual_r=1.
    - Pop of the last word (wcnt=1 single, 3 dual): wcnt <= 0, -> FULL.
  - FULL: fifo_rdreq = 0. Wait for strobe.
- Strobe handling:
  - strobe in FULL: outputs <= staging (registered, visible the cycle after strobe); -> FILL. No pop in the strobe cycle.
  - strobe in FILL (underrun):
    - outputs <= 0; underrun <= 1; ucount++ (saturates at all-ones).
    - Partial staging and wcnt are kept, so word alignment is preserved.
    - If the last word pops in that same cycle, the underrun is still counted, the state moves to FULL, and the completed set is emitted at the next strobe.
  - strobe in IDLE: ignored.
- Latency: from the first strobe after FULL to the outputs changing is 1 clock. The DUC samples the new value at its following strobe (fixed one-strobe pipeline).
- Throughput: one word per clock; a dual set fills in 4 clocks. The minimum DUC strobe period is 2 (rate2=1, rate1=0), so a dual set that is not pre-filled underruns by design.
- clear_status takes priority over a simultaneous underrun: status is 0 after that cycle.
- enable deassert mid-FILL: staged words are discarded. Upstream is required to flush the FIFO before re-enabling.
- Changing dual while enable=1 has no effect until the next IDLE.
- fifo_rdreq is never asserted while fifo_empty=1, in IDLE, or in FULL.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, FILL=2'd1, FULL=2'd2) and the word-order constants (W_I0=0, W_Q0=1, W_I1=2, W_Q1=3).
- No sub-module. Staging regs, FSM and status counter live in one module of about 150-200 lines.

Test Plan:
- Single channel, FIFO preloaded with 0x1111,0x2222,0x3333,0x4444; strobe every 8 clocks -> i0/q0 = 0x1111/0x2222 one clock after strobe #1, then 0x3333/0x4444 after strobe #2; i1/q1 stay 0; underrun stays 0.
- Dual channel, FIFO preloaded with 0xA0,0xA1,0xA2,0xA3; one strobe -> i0,q0,i1,q1 = 0xA0,0xA1,0xA2,0xA3; exactly 4 rdreq pulses.
- FIFO empty with strobe every 4 clocks for 3 strobes -> outputs 0, underrun=1, ucount=3. Then push 0x5555,0x6666 and strobe -> i0/q0 = 0x5555/0x6666.
- Underrun with a partial set (only I0=0x0007 popped) at strobe -> outputs 0, ucount+1. Then push Q0=0x0008 and strobe -> i0/q0 = 0x0007/0x0008, confirming alignment is kept.
- Reset and enable edge cases:
  - Async reset asserted mid-FILL, between clock edges -> all outputs and fifo_rdreq are 0 immediately.
  - enable drop mid-FILL -> state IDLE and staging cleared; underrun/ucount retained until clear_status pulses them to 0.
  - clear_status coinciding with an underrun strobe -> status 0.
- Force ucount to all-ones minus 1, then apply 3 underrun strobes -> ucount saturates at all-ones.

Source files
------------

// File: rtl/tx_sample_unpacker_pkg.sv
// Shared definitions for the TX sample unpacker.
//   state_e        : FSM encoding (IDLE / FILL / FULL)
//   W_I0..W_Q1     : staging slot for each word of an I/Q set, in FIFO order
//   last_word_idx  : staging slot of the final word of a set for a channel mode
package tx_sample_unpacker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  localparam int unsigned W_I0      = 0;
  localparam int unsigned W_Q0      = 1;
  localparam int unsigned W_I1      = 2;
  localparam int unsigned W_Q1      = 3;
  localparam int unsigned NUM_SLOTS = 4;

  function automatic logic [1:0] last_word_idx(input logic dual);
    return dual ? 2'(W_Q1) : 2'(W_Q0);
  endfunction

endpackage

// File: rtl/tx_sample_unpacker.sv
// Pops 16-bit words from a show-ahead TX FIFO, assembles one I/Q set per
// channel and hands it to the DUC on its input strobe. A strobe that finds
// the set incomplete emits zeros and is recorded as an underrun.
//
// Ports:
//   clock, reset          : system clock, async active-high reset
//   enable                : low flushes to IDLE (status is kept)
//   dual                  : 1 = two channels; latched only while in IDLE
//   strobe                : DUC input strobe, one-cycle pulse
//   fifo_data/fifo_empty  : head-of-FIFO word and empty flag
//   fifo_rdreq            : pop request (combinational)
//   i0/q0/i1/q1_out       : registered sample set, updated the cycle after strobe
//   clear_status          : synchronous clear of underrun/ucount
//   underrun, ucount      : sticky flag and saturating underrun count
//
// state | meaning
// IDLE  | flushed; dual latched, staging/outputs held at zero
// FILL  | popping words into staging until the set is complete
// FULL  | complete set staged, waiting for the DUC strobe
module tx_sample_unpacker
  import tx_sample_unpacker_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int UCNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              dual,
  input  logic              strobe,
  input  logic [WIDTH-1:0]  fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  output logic [WIDTH-1:0]  i0_out,
  output logic [WIDTH-1:0]  q0_out,
  output logic [WIDTH-1:0]  i1_out,
  output logic [WIDTH-1:0]  q1_out,
  input  logic              clear_status,
  output logic              underrun,
  output logic [UCNT_W-1:0] ucount
);

  state_e              state_q;
  logic [1:0]          wcnt_q;
  logic [WIDTH-1:0]    stage_q [NUM_SLOTS];
  logic                dual_q;
  logic [WIDTH-1:0]    i0_q, q0_q, i1_q, q1_q;
  logic                underrun_q;
  logic [UCNT_W-1:0]   ucount_q;
  logic [UCNT_W-1:0]   ucount_d;
  logic                pop;
  logic                last_pop;
  logic                underrun_hit;

  // Gated by enable so a word is never popped in the flush cycle and lost.
  assign pop          = enable && (state_q == ST_FILL) && !fifo_empty;
  assign last_pop     = pop && (wcnt_q == last_word_idx(dual_q));
  assign underrun_hit = enable && strobe && (state_q == ST_FILL);
  assign ucount_d     = (&ucount_q) ? ucount_q : ucount_q + UCNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 2'd0;
      dual_q  <= 1'b0;
      i0_q    <= '0;
      q0_q    <= '0;
      i1_q    <= '0;
      q1_q    <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) stage_q[k] <= '0;
    end else if (!enable || state_q == ST_IDLE) begin
      state_q <= enable ? ST_FILL : ST_IDLE;
      wcnt_q  <= 2'd0;
      dual_q  <= dual;
      i0_q    <= '0;
      q0_q    <= '0;
      i1_q    <= '0;
      q1_q    <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) stage_q[k] <= '0;
    end else begin
      unique case (state_q)
        ST_FILL: begin
          // Underrun: emit zeros but keep the partial set so the word
          // alignment of the FIFO stream survives.
          if (strobe) begin
            i0_q <= '0;
            q0_q <= '0;
            i1_q <= '0;
            q1_q <= '0;
          end
          if (pop) begin
            stage_q[wcnt_q] <= fifo_data;
            if (last_pop) begin
              wcnt_q  <= 2'd0;
              state_q <= ST_FULL;
            end else begin
              wcnt_q <= wcnt_q + 2'd1;
            end
          end
        end
        ST_FULL: begin
          if (strobe) begin
            i0_q    <= stage_q[W_I0];
            q0_q    <= stage_q[W_Q0];
            i1_q    <= dual_q ? stage_q[W_I1] : '0;
            q1_q    <= dual_q ? stage_q[W_Q1] : '0;
            state_q <= ST_FILL;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Status survives IDLE; a clear wins over an underrun in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      underrun_q <= 1'b0;
      ucount_q   <= '0;
    end else if (clear_status) begin
      underrun_q <= 1'b0;
      ucount_q   <= '0;
    end else if (underrun_hit) begin
      underrun_q <= 1'b1;
      ucount_q   <= ucount_d;
    end
  end

  assign fifo_rdreq = pop;
  assign i0_out     = i0_q;
  assign q0_out     = q0_q;
  assign i1_out     = i1_q;
  assign q1_out     = q1_q;
  assign underrun   = underrun_q;
  assign ucount     = ucount_q;

endmodule

// File: tb/tb_tx_sample_unpacker.sv
module tb_tx_sample_unpacker;

  localparam int W  = 16;
  localparam int UC = 3;
  localparam int VW = 4 * W + 1 + UC;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          dual = 1'b0;
  logic          strobe = 1'b0;
  logic [W-1:0]  fifo_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rdreq;
  logic [W-1:0]  i0_out, q0_out, i1_out, q1_out;
  logic          clear_status = 1'b0;
  logic          underrun;
  logic [UC-1:0] ucount;

  int checks = 0;
  int passes = 0;
  int pops   = 0;

  tx_sample_unpacker #(.WIDTH(W), .UCNT_W(UC)) dut (
    .clock(clock), .reset(reset), .enable(enable), .dual(dual), .strobe(strobe),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
    .i0_out(i0_out), .q0_out(q0_out), .i1_out(i1_out), .q1_out(q1_out),
    .clear_status(clear_status), .underrun(underrun), .ucount(ucount)
  );

  always #5 clock = ~clock;

  // Environment FIFO (popped by the DUT) and the reference model's own copy.
  logic [W-1:0] hw_fifo[$];
  logic [W-1:0] m_fifo[$];
  // Reference model: words of the set being collected, plus expected outputs.
  logic [W-1:0] m_set[$];
  logic         m_active, m_dual, m_und;
  logic [UC-1:0] m_ucnt;
  logic [W-1:0] e_i0, e_q0, e_i1, e_q1;

  wire [VW-1:0] dut_vec = {i0_out, q0_out, i1_out, q1_out, underrun, ucount};

  function automatic logic [VW-1:0] exp_vec();
    return {e_i0, e_q0, e_i1, e_q1, m_und, m_ucnt};
  endfunction

  function automatic int set_len();
    return m_dual ? 4 : 2;
  endfunction

  function automatic logic m_rdreq();
    return enable && m_active && (m_set.size() < set_len()) && (m_fifo.size() > 0);
  endfunction

  task automatic drive_fifo();
    fifo_empty = (hw_fifo.size() == 0);
    fifo_data  = fifo_empty ? '0 : hw_fifo[0];
  endtask

  task automatic push(input logic [W-1:0] w);
    hw_fifo.push_back(w);
    m_fifo.push_back(w);
    drive_fifo();
  endtask

  task automatic model_reset();
    hw_fifo.delete(); m_fifo.delete(); m_set.delete();
    m_active = 0; m_dual = 0; m_und = 0; m_ucnt = '0;
    e_i0 = '0; e_q0 = '0; e_i1 = '0; e_q1 = '0;
    pops = 0;
    drive_fifo();
  endtask

  // Applies the rules of one clock edge to the model using the current inputs.
  task automatic model_edge();
    logic emitted;
    emitted = 0;
    if (!enable || !m_active) begin
      m_active = enable;
      m_dual = dual;
      m_set.delete();
      e_i0 = '0; e_q0 = '0; e_i1 = '0; e_q1 = '0;
    end else begin
      if (strobe) begin
        if (m_set.size() == set_len()) begin
          e_i0 = m_set[0]; e_q0 = m_set[1];
          e_i1 = m_dual ? m_set[2] : '0;
          e_q1 = m_dual ? m_set[3] : '0;
          m_set.delete();
          emitted = 1;
        end else begin
          e_i0 = '0; e_q0 = '0; e_i1 = '0; e_q1 = '0;
          m_und = 1;
          if (m_ucnt != {UC{1'b1}}) m_ucnt = m_ucnt + 1'b1;
        end
      end
      if (!emitted && m_set.size() < set_len() && m_fifo.size() > 0)
        m_set.push_back(m_fifo.pop_front());
    end
    if (clear_status) begin
      m_und = 0; m_ucnt = '0;
    end
  endtask

  // One clock: settle, advance model and environment FIFO, drop pulses.
  task automatic tick();
    logic pop;
    #1;
    pop = fifo_rdreq;
    model_edge();
    @(posedge clock);
    #1;
    if (pop && hw_fifo.size() > 0) begin
      void'(hw_fifo.pop_front());
      pops++;
    end
    strobe = 0;
    clear_status = 0;
    drive_fifo();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe_tick();
    strobe = 1;
    tick();
  endtask

  task automatic apply_reset();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    enable = 0;
    strobe = 0;
    clear_status = 0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_vec !== '0 || fifo_rdreq !== 1'b0)
      $display("FAIL reset_state: got %h rdreq %b, want 0 rdreq 0", dut_vec, fifo_rdreq);
    else passes++;
  endtask

  task automatic test_single();
    dual = 0; tick();
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    enable = 1;
    ticks(7);
    strobe_tick();
    checks++;
    if (dut_vec !== {16'h1111, 16'h2222, 32'h0, 1'b0, UC'(0)} || dut_vec !== exp_vec())
      $display("FAIL single_set1: got %h want %h", dut_vec, exp_vec());
    else passes++;
    ticks(7);
    strobe_tick();
    checks++;
    if (dut_vec !== {16'h3333, 16'h4444, 32'h0, 1'b0, UC'(0)} || dut_vec !== exp_vec())
      $display("FAIL single_set2: got %h want %h", dut_vec, exp_vec());
    else passes++;
  endtask

  task automatic test_dual();
    enable = 0; dual = 1; tick();
    pops = 0;
    push(16'h00A0); push(16'h00A1); push(16'h00A2); push(16'h00A3);
    enable = 1;
    ticks(7);
    strobe_tick();
    checks++;
    if (dut_vec !== {16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 1'b0, UC'(0)} || dut_vec !== exp_vec())
      $display("FAIL dual_set: got %h want %h", dut_vec, exp_vec());
    else passes++;
    ticks(3);
    checks++;
    if (pops !== 4) $display("FAIL dual_pops: got %0d want 4", pops);
    else passes++;
  endtask

  task automatic test_underrun_empty();
    apply_reset();
    dual = 0; enable = 1;
    ticks(3);
    for (int s = 0; s < 3; s++) begin
      strobe_tick();
      ticks(3);
    end
    checks++;
    if (dut_vec !== {64'h0, 1'b1, UC'(3)} || dut_vec !== exp_vec())
      $display("FAIL underrun_empty: got %h want %h", dut_vec, exp_vec());
    else passes++;
    push(16'h5555); push(16'h6666);
    ticks(4);
    strobe_tick();
    checks++;
    if ({i0_out, q0_out, i1_out, q1_out} !== {16'h5555, 16'h6666, 32'h0} || dut_vec !== exp_vec())
      $display("FAIL underrun_recover: got %h want %h", dut_vec, exp_vec());
    else passes++;
  endtask

  task automatic test_partial();
    clear_status = 1; tick();
    push(16'h0007);
    ticks(3);
    strobe_tick();
    checks++;
    if (dut_vec !== {64'h0, 1'b1, UC'(1)} || dut_vec !== exp_vec())
      $display("FAIL partial_underrun: got %h want %h", dut_vec, exp_vec());
    else passes++;
    push(16'h0008);
    ticks(3);
    strobe_tick();
    checks++;
    if ({i0_out, q0_out} !== {16'h0007, 16'h0008} || dut_vec !== exp_vec())
      $display("FAIL partial_align: got %h want %h", dut_vec, exp_vec());
    else passes++;
  endtask

  task automatic test_async_reset();
    push(16'h0909); push(16'h0A0A); push(16'h0B0B);
    tick();
    #2;
    checks++;
    if (fifo_rdreq !== 1'b1 || i0_out !== 16'h0007)
      $display("FAIL pre_reset_fill: got rdreq %b i0 %h want 1 0007", fifo_rdreq, i0_out);
    else passes++;
    reset = 1;
    #1;
    checks++;
    if (dut_vec !== '0 || fifo_rdreq !== 1'b0)
      $display("FAIL async_reset: got %h rdreq %b want 0 rdreq 0", dut_vec, fifo_rdreq);
    else passes++;
    apply_reset();
  endtask

  task automatic test_enable_drop();
    dual = 0; enable = 1;
    tick();
    strobe_tick();
    push(16'h00EE);
    ticks(3);
    enable = 0;
    tick();
    checks++;
    if (dut_vec !== {64'h0, 1'b1, UC'(1)} || dut_vec !== exp_vec())
      $display("FAIL enable_drop: got %h want %h", dut_vec, exp_vec());
    else passes++;
    enable = 1;
    push(16'h00AA); push(16'h00BB);
    ticks(5);
    strobe_tick();
    checks++;
    if ({i0_out, q0_out} !== {16'h00AA, 16'h00BB} || dut_vec !== exp_vec())
      $display("FAIL enable_restage: got %h want %h", dut_vec, exp_vec());
    else passes++;
    clear_status = 1; tick();
    checks++;
    if ({underrun, ucount} !== '0 || dut_vec !== exp_vec())
      $display("FAIL clear_status: got %b/%0d want 0/0", underrun, ucount);
    else passes++;
  endtask

  task automatic test_clear_collision();
    ticks(2);
    strobe_tick();
    checks++;
    if ({underrun, ucount} !== {1'b1, UC'(1)})
      $display("FAIL collide_setup: got %b/%0d want 1/1", underrun, ucount);
    else passes++;
    strobe = 1; clear_status = 1; tick();
    checks++;
    if ({underrun, ucount} !== '0 || dut_vec !== exp_vec())
      $display("FAIL clear_collision: got %b/%0d want 0/0", underrun, ucount);
    else passes++;
  endtask

  task automatic test_saturate();
    for (int s = 0; s < 6; s++) begin
      strobe_tick();
      tick();
    end
    checks++;
    if (ucount !== UC'(6)) $display("FAIL sat_setup: got %0d want 6", ucount);
    else passes++;
    for (int s = 0; s < 3; s++) begin
      strobe_tick();
      tick();
    end
    checks++;
    if (ucount !== {UC{1'b1}} || underrun !== 1'b1 || dut_vec !== exp_vec())
      $display("FAIL saturate: got %0d want %0d", ucount, {UC{1'b1}});
    else passes++;
  endtask

  task automatic test_random(input logic d, input int ncyc);
    int gap;
    int errs;
    errs = 0;
    enable = 0; dual = d; tick();
    clear_status = 1; tick();
    enable = 1;
    gap = 4;
    for (int c = 0; c < ncyc; c++) begin
      if (hw_fifo.size() < 8 && $urandom_range(0, 2) != 0) push(W'($urandom));
      if (--gap == 0) begin
        strobe = 1;
        gap = $urandom_range(2, 6);
      end
      if ($urandom_range(0, 59) == 0) clear_status = 1;
      if ($urandom_range(0, 99) == 0) dual = ~dual;
      #1;
      checks++;
      if (fifo_rdreq !== m_rdreq()) begin
        errs++;
        if (errs < 10) $display("FAIL rand_rdreq c%0d: got %b want %b", c, fifo_rdreq, m_rdreq());
      end else passes++;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errs++;
        if (errs < 10) $display("FAIL rand_out c%0d: got %h want %h", c, dut_vec, exp_vec());
      end else passes++;
    end
    dual = d;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_dual();
    test_underrun_empty();
    test_partial();
    test_async_reset();
    test_enable_drop();
    test_clear_collision();
    test_saturate();
    test_random(1'b0, 400);
    test_random(1'b1, 400);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
